// File: rtl/mycpu_pkg.sv
// Shared types and encodings for the CPU control unit: opcodes, FSM states,
// PC-select / write-back-mux codes and ALU function-select values.
package mycpu_pkg;

   localparam int unsigned OPC_W = 7;
   localparam int unsigned FS_W  = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_MOVA = 7'h00, OP_INC  = 7'h01, OP_ADD  = 7'h02, OP_MUL  = 7'h03,
      OP_SRA  = 7'h04, OP_SUB  = 7'h05, OP_DEC  = 7'h06, OP_SLA  = 7'h07,
      OP_AND  = 7'h08, OP_OR   = 7'h09, OP_XOR  = 7'h0A, OP_NOT  = 7'h0B,
      OP_MOVB = 7'h0C, OP_SHR  = 7'h0D, OP_SHL  = 7'h0E, OP_CLR  = 7'h0F,
      OP_LDI  = 7'h10, OP_ADI  = 7'h11,
      OP_BRZ  = 7'h20, OP_BRN  = 7'h21, OP_JMP  = 7'h22,
      OP_LD   = 7'h30, OP_ST   = 7'h31, OP_IOR  = 7'h32, OP_IOW  = 7'h33,
      OP_XXL  = 7'h40,
      OP_HAL  = 7'h50
   } opcode_t;

   typedef enum logic [2:0] {
      S_RST, S_INF, S_EX0, S_MWT, S_XL0, S_HLT, S_ERR
   } cu_state_t;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_BR   = 2'b10;
   localparam logic [1:0] PS_JMP  = 2'b11;

   localparam logic [1:0] MD_ALU  = 2'b00;
   localparam logic [1:0] MD_MEM  = 2'b01;
   localparam logic [1:0] MD_IO   = 2'b10;

   localparam logic [FS_W-1:0] FS_MOVA = 4'h0, FS_INC = 4'h1, FS_ADD  = 4'h2,
                               FS_MUL  = 4'h3, FS_SRA = 4'h4, FS_SUB  = 4'h5,
                               FS_DEC  = 4'h6, FS_SLA = 4'h7, FS_AND  = 4'h8,
                               FS_OR   = 4'h9, FS_XOR = 4'hA, FS_NOT  = 4'hB,
                               FS_MOVB = 4'hC, FS_SHR = 4'hD, FS_SHL  = 4'hE,
                               FS_CLR  = 4'hF;

   // ALU function for the single-cycle register ops.
   function automatic logic [FS_W-1:0] alu_fs(input opcode_t op);
      case (op)
         OP_INC:  return FS_INC;
         OP_ADD:  return FS_ADD;
         OP_MUL:  return FS_MUL;
         OP_SRA:  return FS_SRA;
         OP_SUB:  return FS_SUB;
         OP_DEC:  return FS_DEC;
         OP_SLA:  return FS_SLA;
         OP_AND:  return FS_AND;
         OP_OR:   return FS_OR;
         OP_XOR:  return FS_XOR;
         OP_NOT:  return FS_NOT;
         OP_MOVB: return FS_MOVB;
         OP_SHR:  return FS_SHR;
         OP_SHL:  return FS_SHL;
         OP_CLR:  return FS_CLR;
         default: return FS_MOVA;
      endcase
   endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Saturating up-counter with synchronous clear (priority over enable) and a
// terminal-count flag that is high while the count equals MAX.
module cu_wait_timer #(
   parameter int unsigned MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [CW-1:0] cnt;

   assign tc_c = (cnt == CW'(MAX));

   // Holds at MAX instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc_c) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle CPU control unit with memory/IO ready handshake, bounded shift
// loop and halt/error status. Define CU_TIMEOUT_EN to bound stalls by WAIT_MAX.
module cu_seq #(
   parameter int unsigned IW       = 16,
   parameter int unsigned OPW      = 7,
   parameter int unsigned RAW      = 3,
   parameter int unsigned FSW      = 4,
   parameter int unsigned LOOP_MAX = 16,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IW-1:0]        ins_in,
   input  logic                 z_in,
   input  logic                 n_in,
   input  logic                 rdy_in,
   output logic                 il_out,
   output logic [1:0]           ps_out,
   output logic                 rw_out,
   output logic [3*(RAW+1)-1:0] rs_out,
   output logic                 mm_out,
   output logic [1:0]           md_out,
   output logic                 mb_out,
   output logic [FSW-1:0]       fs_out,
   output logic                 wen_out,
   output logic                 iom_out,
   output logic                 halt_out,
   output logic                 err_out
);

   import mycpu_pkg::*;

   localparam int unsigned RSW = 3 * (RAW + 1);

   cu_state_t      state, state_nx;
   opcode_t        op;
   logic [RAW-1:0] dst, srca, srcb;
   logic [RSW-1:0] rs_map, rs_xl;
   logic           loop_clr, loop_en, loop_tc;
   logic           wait_tc;
   logic [1:0]     mem_md;
   logic           mem_wen, mem_iom, mem_rd;

   assign op     = opcode_t'(OPC_W'(ins_in[IW-1 -: OPW]));
   assign dst    = ins_in[3*RAW-1 -: RAW];
   assign srca   = ins_in[2*RAW-1 -: RAW];
   assign srcb   = ins_in[RAW-1:0];
   assign rs_map = {1'b0, dst, 1'b0, srca, 1'b0, srcb};
   assign rs_xl  = {1'b0, {RAW{1'b0}}, 1'b0, srca, 1'b0, srcb};

   cu_wait_timer #(.MAX(LOOP_MAX)) u_loop (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (loop_clr),
      .en    (loop_en),
      .tc_c  (loop_tc)
   );

`ifdef CU_TIMEOUT_EN
   logic wait_run;

   // Counts only while actually stalled; any exit from INF/MWT clears it.
   assign wait_run = ((state == S_INF) || (state == S_MWT)) && !rdy_in;

   cu_wait_timer #(.MAX(WAIT_MAX)) u_wait (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!wait_run),
      .en    (wait_run),
      .tc_c  (wait_tc)
   );
`else
   logic unused_wait_max;

   assign wait_tc         = 1'b0;
   assign unused_wait_max = |WAIT_MAX;
`endif

   // Memory/IO control lines shared by EX0 and MWT.
   always_comb begin
      mem_md  = MD_ALU;
      mem_wen = 1'b1;
      mem_iom = 1'b0;
      mem_rd  = 1'b0;
      case (op)
         OP_LD:  begin mem_md = MD_MEM; mem_rd = 1'b1; end
         OP_ST:  mem_wen = 1'b0;
         OP_IOR: begin mem_md = MD_IO; mem_iom = 1'b1; mem_rd = 1'b1; end
         OP_IOW: begin mem_wen = 1'b0; mem_iom = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_RST;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      il_out   = 1'b0;
      ps_out   = PS_HOLD;
      rw_out   = 1'b0;
      rs_out   = rs_map;
      mm_out   = 1'b0;
      md_out   = MD_ALU;
      mb_out   = 1'b0;
      fs_out   = '0;
      wen_out  = 1'b1;
      iom_out  = 1'b0;
      halt_out = 1'b0;
      err_out  = 1'b0;
      loop_clr = 1'b1;
      loop_en  = 1'b0;

      case (state)
         S_RST: begin
            rs_out   = '0;
            state_nx = S_INF;
         end

         S_INF: begin
            mm_out = 1'b1;
            if (rdy_in) begin
               il_out   = 1'b1;
               state_nx = S_EX0;
            end else if (wait_tc) begin
               state_nx = S_ERR;
            end
         end

         S_EX0: begin
            state_nx = S_INF;
            case (op)
               OP_MOVA, OP_INC, OP_ADD, OP_MUL, OP_SRA, OP_SUB, OP_DEC, OP_SLA,
               OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL, OP_CLR: begin
                  ps_out = PS_INC;
                  rw_out = 1'b1;
                  fs_out = FSW'(alu_fs(op));
               end
               OP_LDI: begin
                  ps_out = PS_INC;
                  rw_out = 1'b1;
                  fs_out = FSW'(FS_MOVB);
                  mb_out = 1'b1;
               end
               OP_ADI: begin
                  ps_out = PS_INC;
                  rw_out = 1'b1;
                  fs_out = FSW'(FS_ADD);
                  mb_out = 1'b1;
               end
               OP_BRZ: begin
                  md_out = MD_MEM;
                  ps_out = z_in ? PS_BR : PS_INC;
               end
               OP_BRN: begin
                  md_out = MD_MEM;
                  ps_out = n_in ? PS_BR : PS_INC;
               end
               OP_JMP: ps_out = PS_JMP;
               OP_LD, OP_ST, OP_IOR, OP_IOW: begin
                  md_out  = mem_md;
                  wen_out = mem_wen;
                  iom_out = mem_iom;
                  if (rdy_in) begin
                     ps_out = PS_INC;
                     rw_out = mem_rd;
                  end else begin
                     state_nx = S_MWT;
                  end
               end
               OP_XXL: begin
                  fs_out   = FSW'(FS_SHL);
                  iom_out  = 1'b1;
                  wen_out  = 1'b0;
                  rs_out   = '0;
                  loop_clr = 1'b0;
                  loop_en  = 1'b1;
                  state_nx = S_XL0;
               end
               default: state_nx = S_HLT;
            endcase
         end

         S_MWT: begin
            md_out  = mem_md;
            wen_out = mem_wen;
            iom_out = mem_iom;
            if (rdy_in) begin
               ps_out   = PS_INC;
               rw_out   = mem_rd;
               state_nx = S_INF;
            end else if (wait_tc) begin
               state_nx = S_ERR;
            end
         end

         // Shift loop: each pass re-issues SHL into R0 until zero or the cap.
         S_XL0: begin
            iom_out = 1'b1;
            if (z_in || loop_tc) begin
               ps_out   = PS_INC;
               state_nx = S_INF;
            end else begin
               fs_out   = FSW'(FS_SHL);
               rw_out   = 1'b1;
               rs_out   = rs_xl;
               loop_clr = 1'b0;
               loop_en  = 1'b1;
            end
         end

         S_HLT: halt_out = 1'b1;

         S_ERR: begin
`ifdef CU_TIMEOUT_EN
            err_out = 1'b1;
`endif
         end

         default: state_nx = S_RST;
      endcase
   end

endmodule

// File: tb/tb_cu_seq.sv
// Scoreboard bench for cu_seq: the driver queues the expected control vector
// for every cycle it drives; a negedge monitor pops and compares.
module tb_cu_seq;

   localparam int unsigned VW = 28;

   logic        clk;
   logic        rst_n;
   logic [15:0] ins_in;
   logic        z_in, n_in, rdy_in;
   logic        il_out, rw_out, mm_out, mb_out, wen_out, iom_out, halt_out, err_out;
   logic [1:0]  ps_out, md_out;
   logic [11:0] rs_out;
   logic [3:0]  fs_out;
   logic [VW-1:0] dut_v;

   int checks = 0;
   int errors = 0;

   logic [VW-1:0] eq[$];
   string         tq[$];

   cu_seq #(
      .IW(16), .OPW(7), .RAW(3), .FSW(4), .LOOP_MAX(4), .WAIT_MAX(15)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ins_in   (ins_in),
      .z_in     (z_in),
      .n_in     (n_in),
      .rdy_in   (rdy_in),
      .il_out   (il_out),
      .ps_out   (ps_out),
      .rw_out   (rw_out),
      .rs_out   (rs_out),
      .mm_out   (mm_out),
      .md_out   (md_out),
      .mb_out   (mb_out),
      .fs_out   (fs_out),
      .wen_out  (wen_out),
      .iom_out  (iom_out),
      .halt_out (halt_out),
      .err_out  (err_out)
   );

   assign dut_v = {il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out,
                   fs_out, wen_out, iom_out, halt_out, err_out};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VW-1:0] ev(input logic il, input logic [1:0] ps,
                                        input logic rw, input logic [11:0] rs,
                                        input logic mm, input logic [1:0] md,
                                        input logic mb, input logic [3:0] fs,
                                        input logic wen, input logic iom,
                                        input logic halt, input logic err);
      return {il, ps, rw, rs, mm, md, mb, fs, wen, iom, halt, err};
   endfunction

   function automatic logic [VW-1:0] e_rst();
      return ev(1'b0, 2'b00, 1'b0, 12'h000, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic [VW-1:0] e_inf(input logic il, input logic [11:0] rs);
      return ev(il, 2'b00, 1'b0, rs, 1'b1, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
      return {op, d, a, b};
   endfunction

   // Drive one cycle's inputs just after the edge and queue its expectation.
   task automatic cyc(input logic rn, input logic [15:0] i, input logic z,
                      input logic n, input logic r, input string tag,
                      input logic [VW-1:0] e);
      @(posedge clk);
      #1;
      rst_n  = rn;
      ins_in = i;
      z_in   = z;
      n_in   = n;
      rdy_in = r;
      tq.push_back(tag);
      eq.push_back(e);
   endtask

   task automatic fetch(input logic [15:0] i, input logic [11:0] rs, input string tag);
      cyc(1'b1, i, 1'b0, 1'b0, 1'b1, tag, e_inf(1'b1, rs));
   endtask

   always @(negedge clk) begin
      if (eq.size() > 0) begin
         logic [VW-1:0] e;
         string t;
         e = eq.pop_front();
         t = tq.pop_front();
         checks++;
         if (dut_v !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", t, dut_v, e, $time);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] i_add, i_ld, i_st, i_ior, i_iow, i_brz, i_brn, i_jmp;
      logic [15:0] i_ldi, i_adi, i_xor, i_clr, i_xxl, i_und, i_hal;

      i_add = mk(7'h02, 3'd1, 3'd2, 3'd3);
      i_ld  = mk(7'h30, 3'd1, 3'd2, 3'd0);
      i_st  = mk(7'h31, 3'd0, 3'd4, 3'd5);
      i_ior = mk(7'h32, 3'd3, 3'd0, 3'd0);
      i_iow = mk(7'h33, 3'd0, 3'd6, 3'd7);
      i_brz = mk(7'h20, 3'd0, 3'd0, 3'd0);
      i_brn = mk(7'h21, 3'd0, 3'd0, 3'd0);
      i_jmp = mk(7'h22, 3'd0, 3'd0, 3'd0);
      i_ldi = mk(7'h10, 3'd2, 3'd0, 3'd0);
      i_adi = mk(7'h11, 3'd5, 3'd5, 3'd1);
      i_xor = mk(7'h0A, 3'd1, 3'd1, 3'd1);
      i_clr = mk(7'h0F, 3'd7, 3'd0, 3'd0);
      i_xxl = mk(7'h40, 3'd3, 3'd1, 3'd2);
      i_und = mk(7'h7F, 3'd1, 3'd2, 3'd3);
      i_hal = mk(7'h50, 3'd1, 3'd2, 3'd3);

      rst_n = 1'b0; ins_in = '0; z_in = 1'b0; n_in = 1'b0; rdy_in = 1'b0;

      cyc(1'b0, i_add, 1'b0, 1'b0, 1'b1, "rst_hold", e_rst());
      cyc(1'b0, i_add, 1'b0, 1'b0, 1'b1, "rst_hold2", e_rst());
      cyc(1'b1, i_add, 1'b0, 1'b0, 1'b1, "rst_release", e_rst());

      // ADD R1,R2,R3; rdy low in EX0 must not matter
      fetch(i_add, 12'h123, "add_fetch");
      cyc(1'b1, i_add, 1'b0, 1'b0, 1'b0, "add_ex0",
          ev(0, 2'b01, 1, 12'h123, 0, 2'b00, 0, 4'h2, 1, 0, 0, 0));

      // fetch stall then LD stalled three cycles
      cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b0, "inf_stall", e_inf(1'b0, 12'h120));
      cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b0, "inf_stall2", e_inf(1'b0, 12'h120));
      fetch(i_ld, 12'h120, "ld_fetch");
      cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b0, "ld_ex0_wait",
          ev(0, 2'b00, 0, 12'h120, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));
      for (int k = 0; k < 2; k++)
         cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b0, "ld_mwt_hold",
             ev(0, 2'b00, 0, 12'h120, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));
      cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b1, "ld_mwt_done",
          ev(0, 2'b01, 1, 12'h120, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));

      fetch(i_st, 12'h045, "st_fetch");
      cyc(1'b1, i_st, 1'b0, 1'b0, 1'b1, "st_ex0",
          ev(0, 2'b01, 0, 12'h045, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0));
      fetch(i_ior, 12'h300, "ior_fetch");
      cyc(1'b1, i_ior, 1'b0, 1'b0, 1'b1, "ior_ex0",
          ev(0, 2'b01, 1, 12'h300, 0, 2'b10, 0, 4'h0, 1, 1, 0, 0));
      fetch(i_iow, 12'h067, "iow_fetch");
      cyc(1'b1, i_iow, 1'b0, 1'b0, 1'b0, "iow_ex0_wait",
          ev(0, 2'b00, 0, 12'h067, 0, 2'b00, 0, 4'h0, 0, 1, 0, 0));
      cyc(1'b1, i_iow, 1'b0, 1'b0, 1'b1, "iow_mwt_done",
          ev(0, 2'b01, 0, 12'h067, 0, 2'b00, 0, 4'h0, 0, 1, 0, 0));

      // branches: each must follow its own flag only
      fetch(i_brz, 12'h000, "brz_fetch");
      cyc(1'b1, i_brz, 1'b1, 1'b0, 1'b1, "brz_taken",
          ev(0, 2'b10, 0, 12'h000, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));
      fetch(i_brz, 12'h000, "brz_fetch2");
      cyc(1'b1, i_brz, 1'b0, 1'b1, 1'b1, "brz_not",
          ev(0, 2'b01, 0, 12'h000, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));
      fetch(i_brn, 12'h000, "brn_fetch");
      cyc(1'b1, i_brn, 1'b0, 1'b1, 1'b1, "brn_taken",
          ev(0, 2'b10, 0, 12'h000, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));
      fetch(i_brn, 12'h000, "brn_fetch2");
      cyc(1'b1, i_brn, 1'b1, 1'b0, 1'b1, "brn_not",
          ev(0, 2'b01, 0, 12'h000, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));
      fetch(i_jmp, 12'h000, "jmp_fetch");
      cyc(1'b1, i_jmp, 1'b0, 1'b0, 1'b1, "jmp_ex0",
          ev(0, 2'b11, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0, 0));

      // immediates and more ALU selects
      fetch(i_ldi, 12'h200, "ldi_fetch");
      cyc(1'b1, i_ldi, 1'b0, 1'b0, 1'b1, "ldi_ex0",
          ev(0, 2'b01, 1, 12'h200, 0, 2'b00, 1, 4'hC, 1, 0, 0, 0));
      fetch(i_adi, 12'h551, "adi_fetch");
      cyc(1'b1, i_adi, 1'b0, 1'b0, 1'b1, "adi_ex0",
          ev(0, 2'b01, 1, 12'h551, 0, 2'b00, 1, 4'h2, 1, 0, 0, 0));
      fetch(i_xor, 12'h111, "xor_fetch");
      cyc(1'b1, i_xor, 1'b0, 1'b0, 1'b1, "xor_ex0",
          ev(0, 2'b01, 1, 12'h111, 0, 2'b00, 0, 4'hA, 1, 0, 0, 0));
      fetch(i_clr, 12'h700, "clr_fetch");
      cyc(1'b1, i_clr, 1'b0, 1'b0, 1'b1, "clr_ex0",
          ev(0, 2'b01, 1, 12'h700, 0, 2'b00, 0, 4'hF, 1, 0, 0, 0));

      // shift loop to the cap (LOOP_MAX=4): EX0 plus three re-issues
      fetch(i_xxl, 12'h312, "xxl_fetch");
      cyc(1'b1, i_xxl, 1'b0, 1'b0, 1'b1, "xxl_ex0",
          ev(0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'hE, 0, 1, 0, 0));
      for (int k = 0; k < 3; k++)
         cyc(1'b1, i_xxl, 1'b0, 1'b0, 1'b0, "xxl_iter",
             ev(0, 2'b00, 1, 12'h012, 0, 2'b00, 0, 4'hE, 1, 1, 0, 0));
      cyc(1'b1, i_xxl, 1'b0, 1'b0, 1'b0, "xxl_cap_exit",
          ev(0, 2'b01, 0, 12'h312, 0, 2'b00, 0, 4'h0, 1, 1, 0, 0));

      // shift loop with zero flag on the second iteration
      fetch(i_xxl, 12'h312, "xxl2_fetch");
      cyc(1'b1, i_xxl, 1'b0, 1'b0, 1'b1, "xxl2_ex0",
          ev(0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'hE, 0, 1, 0, 0));
      cyc(1'b1, i_xxl, 1'b0, 1'b0, 1'b1, "xxl2_iter",
          ev(0, 2'b00, 1, 12'h012, 0, 2'b00, 0, 4'hE, 1, 1, 0, 0));
      cyc(1'b1, i_xxl, 1'b1, 1'b0, 1'b1, "xxl2_z_exit",
          ev(0, 2'b01, 0, 12'h312, 0, 2'b00, 0, 4'h0, 1, 1, 0, 0));

      // undefined opcode halts and stays halted
      fetch(i_und, 12'h123, "und_fetch");
      cyc(1'b1, i_und, 1'b0, 1'b0, 1'b1, "und_ex0",
          ev(0, 2'b00, 0, 12'h123, 0, 2'b00, 0, 4'h0, 1, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         cyc(1'b1, i_und, 1'b0, 1'b0, k[0], "hlt_sticky",
             ev(0, 2'b00, 0, 12'h123, 0, 2'b00, 0, 4'h0, 1, 0, 1, 0));

      cyc(1'b0, i_ld, 1'b0, 1'b0, 1'b1, "hlt_reset", e_rst());
      cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b1, "rst_release2", e_rst());
      fetch(i_ld, 12'h120, "ld2_fetch");
      cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b0, "ld2_ex0_wait",
          ev(0, 2'b00, 0, 12'h120, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));
      cyc(1'b1, i_ld, 1'b0, 1'b0, 1'b0, "ld2_mwt_hold",
          ev(0, 2'b00, 0, 12'h120, 0, 2'b01, 0, 4'h0, 1, 0, 0, 0));

      // async reset mid-MWT, away from any clock edge
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_v !== e_rst()) begin
         errors++;
         $display("FAIL async_rst_mid_mwt: got %h expected %h", dut_v, e_rst());
      end

      cyc(1'b0, i_hal, 1'b0, 1'b0, 1'b0, "rst_hold3", e_rst());
      cyc(1'b1, i_hal, 1'b0, 1'b0, 1'b0, "rst_release3", e_rst());
      fetch(i_hal, 12'h123, "hal_fetch");
      cyc(1'b1, i_hal, 1'b0, 1'b0, 1'b1, "hal_ex0",
          ev(0, 2'b00, 0, 12'h123, 0, 2'b00, 0, 4'h0, 1, 0, 0, 0));
      cyc(1'b1, i_hal, 1'b0, 1'b0, 1'b1, "hal_hlt",
          ev(0, 2'b00, 0, 12'h123, 0, 2'b00, 0, 4'h0, 1, 0, 1, 0));

      cyc(1'b0, i_add, 1'b0, 1'b0, 1'b0, "rst_hold4", e_rst());
      cyc(1'b1, i_add, 1'b0, 1'b0, 1'b0, "rst_release4", e_rst());
`ifdef CU_TIMEOUT_EN
      // counts 0..15 in INF, error raised once the count sits at WAIT_MAX
      for (int k = 0; k < 16; k++)
         cyc(1'b1, i_add, 1'b0, 1'b0, 1'b0, "to_stall", e_inf(1'b0, 12'h123));
      for (int k = 0; k < 3; k++)
         cyc(1'b1, i_add, 1'b0, 1'b0, 1'b1, "err_sticky",
             ev(0, 2'b00, 0, 12'h123, 0, 2'b00, 0, 4'h0, 1, 0, 0, 1));
      cyc(1'b0, i_add, 1'b0, 1'b0, 1'b1, "err_reset", e_rst());
`else
      for (int k = 0; k < 20; k++)
         cyc(1'b1, i_add, 1'b0, 1'b0, 1'b0, "long_stall", e_inf(1'b0, 12'h123));
      fetch(i_add, 12'h123, "stall_recover");
`endif

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (eq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", eq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
